// File: rtl/johnson_monitor.sv
// Johnson code monitor: decodes a registered 4-bit Johnson code,
// tracks legal advances and counts revolutions with lock/recovery.
module johnson_monitor #(
    parameter int CYCLE_W    = 8,
    parameter int RESYNC_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         code_in,
    input  logic               clear,
    output logic [2:0]         index,
    output logic               index_valid,
    output logic               step,
    output logic               wrap,
    output logic [CYCLE_W-1:0] cycles,
    output logic               illegal,
    output logic               seq_err,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } st_t;

    localparam logic [3:0] RL = 4'(RESYNC_LEN);

    st_t        st;
    logic [3:0] code_q;
    logic       code_q_vld;
    logic [2:0] prev_idx;
    logic [3:0] good_cnt;
    logic [2:0] idx;
    logic       legal;
    logic [2:0] d;

    assign state = st;
    assign d     = idx - prev_idx;

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (code_q)
            4'b0000: idx = 3'd0;
            4'b1000: idx = 3'd1;
            4'b1100: idx = 3'd2;
            4'b1110: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b0111: idx = 3'd5;
            4'b0011: idx = 3'd6;
            4'b0001: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= SYNC;
            code_q      <= 4'd0;
            code_q_vld  <= 1'b0;
            prev_idx    <= 3'd0;
            good_cnt    <= 4'd0;
            index       <= 3'd0;
            index_valid <= 1'b0;
            step        <= 1'b0;
            wrap        <= 1'b0;
            cycles      <= '0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            code_q     <= code_in;
            code_q_vld <= 1'b1;
            step       <= 1'b0;
            wrap       <= 1'b0;
            illegal    <= code_q_vld && !legal;
            if (clear) begin
                st          <= SYNC;
                cycles      <= '0;
                seq_err     <= 1'b0;
                good_cnt    <= 4'd0;
                index_valid <= 1'b0;
            end else if (code_q_vld) begin
                case (st)
                    SYNC: begin
                        if (legal) begin
                            prev_idx    <= idx;
                            index       <= idx;
                            index_valid <= 1'b1;
                            st          <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (legal && d == 3'd1) begin
                            step     <= 1'b1;
                            index    <= idx;
                            prev_idx <= idx;
                            if (prev_idx == 3'd7) begin
                                wrap   <= 1'b1;
                                cycles <= cycles + CYCLE_W'(1);
                            end
                        end else if (!(legal && d == 3'd0)) begin
                            // a legal jump still seeds the resync reference
                            if (legal)
                                prev_idx <= idx;
                            st          <= ERROR;
                            seq_err     <= 1'b1;
                            good_cnt    <= 4'd0;
                            index_valid <= 1'b0;
                        end
                    end
                    ERROR: begin
                        index_valid <= 1'b0;
                        if (!legal) begin
                            good_cnt <= 4'd0;
                        end else if (d == 3'd1) begin
                            prev_idx <= idx;
                            if (good_cnt + 4'd1 >= RL) begin
                                st          <= TRACK;
                                index       <= idx;
                                index_valid <= 1'b1;
                                good_cnt    <= 4'd0;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else if (d != 3'd0) begin
                            prev_idx <= idx;
                            good_cnt <= 4'd0;
                        end
                    end
                    default: st <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed bench for johnson_monitor; a CYCLE_W=2 twin
// shares the stimulus to exercise counter wraparound.
module tb_johnson_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code_in;
    logic       clear;

    logic [2:0] index, index2;
    logic       index_valid, index_valid2;
    logic       step, step2;
    logic       wrap, wrap2;
    logic [7:0] cycles;
    logic [1:0] cycles2;
    logic       illegal, illegal2;
    logic       seq_err, seq_err2;
    logic [1:0] state, state2;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] jc [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

    johnson_monitor dut (
        .clk(clk), .reset(reset), .code_in(code_in), .clear(clear),
        .index(index), .index_valid(index_valid), .step(step),
        .wrap(wrap), .cycles(cycles), .illegal(illegal),
        .seq_err(seq_err), .state(state)
    );

    johnson_monitor #(.CYCLE_W(2)) dut2 (
        .clk(clk), .reset(reset), .code_in(code_in), .clear(clear),
        .index(index2), .index_valid(index_valid2), .step(step2),
        .wrap(wrap2), .cycles(cycles2), .illegal(illegal2),
        .seq_err(seq_err2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] c);
        code_in = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        code_in = 4'b0000;
        #2;
        chk("rst_state", state, 2'b00);
        chk("rst_index", index, 3'd0);
        chk("rst_ivld", index_valid, 1'b0);
        chk("rst_cycles", cycles, 8'd0);
        chk("rst_flags", {step, wrap, illegal, seq_err}, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // test 1: full revolution; reset code_q must not lock
        apply(jc[0]);
        chk("t1_nolock", state, 2'b00);
        for (int i = 1; i <= 9; i++) begin
            apply(jc[i % 8]);
            chk("t1_state", state, 2'b01);
            chk("t1_index", index, 32'((i - 1) % 8));
            chk("t1_step", step, (i > 1) ? 1 : 0);
            chk("t1_wrap", wrap, (i == 9) ? 1 : 0);
        end
        chk("t1_cycles", cycles, 8'd1);
        chk("t1_cycles2", cycles2, 2'd1);
        chk("t1_seqerr", seq_err, 1'b0);

        // test 2: hold then advance
        apply(4'b1100);
        chk("t2_s1", {step, index}, {1'b1, 3'd1});
        apply(4'b1100);
        chk("t2_s2", {step, index}, {1'b1, 3'd2});
        apply(4'b1100);
        chk("t2_h1", {step, index}, {1'b0, 3'd2});
        apply(4'b1110);
        chk("t2_h2", {step, index}, {1'b0, 3'd2});
        apply(4'b1110);
        chk("t2_s3", {step, index}, {1'b1, 3'd3});

        // test 3: clear, relock at 1, jump, resync
        clear = 1'b1;
        apply(4'b1000);
        clear = 1'b0;
        chk("t3_clr_state", state, 2'b00);
        chk("t3_clr_cyc", cycles, 8'd0);
        chk("t3_clr_cyc2", cycles2, 2'd0);
        apply(4'b1110);
        chk("t3_lock", {state, index, index_valid}, {2'b01, 3'd1, 1'b1});
        apply(4'b1111);
        chk("t3_err", {state, seq_err, index_valid}, {2'b10, 1'b1, 1'b0});
        chk("t3_idx_hold", index, 3'd1);
        apply(4'b0111);
        chk("t3_g1", state, 2'b10);
        apply(4'b0011);
        chk("t3_g2", state, 2'b10);
        apply(4'b0001);
        chk("t3_g3", state, 2'b10);
        apply(4'b0001);
        chk("t3_resync", {state, index, index_valid}, {2'b01, 3'd7, 1'b1});
        chk("t3_nostep", step, 1'b0);
        chk("t3_sticky", seq_err, 1'b1);

        // test 4: illegal codes in TRACK and SYNC
        apply(4'b1010);
        chk("t4_hold", {state, illegal}, {2'b01, 1'b0});
        apply(4'b0000);
        chk("t4_ill", {state, illegal}, {2'b10, 1'b1});
        apply(4'b0000);
        chk("t4_ill_1cyc", {state, illegal}, {2'b10, 1'b0});
        clear = 1'b1;
        apply(4'b0101);
        clear = 1'b0;
        chk("t4_clr", {state, seq_err}, {2'b00, 1'b0});
        apply(4'b0000);
        chk("t4_sync_ill", {state, illegal}, {2'b00, 1'b1});
        apply(4'b0000);
        chk("t4_relock", {state, illegal, index}, {2'b01, 1'b0, 3'd0});

        // test 5: four revolutions, narrow counter wraps to 0
        for (int n = 1; n <= 33; n++) begin
            apply(jc[n % 8]);
            chk("t5_step", step, (n > 1) ? 1 : 0);
            chk("t5_wrap2", wrap2, (n > 1 && (n - 1) % 8 == 0) ? 1 : 0);
            chk("t5_cyc2", cycles2, 32'(((n - 1) / 8) % 4));
            chk("t5_cyc", cycles, 32'((n - 1) / 8));
        end

        // test 6: async reset between edges, then clear in ERROR
        reset = 1'b0;
        #2;
        chk("t6_rst_state", state, 2'b00);
        chk("t6_rst_cyc", cycles, 8'd0);
        chk("t6_rst_out", {index, index_valid, step, wrap},
            {3'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(4'b1000);
        chk("t6_nolock", state, 2'b00);
        apply(4'b1110);
        chk("t6_lock", {state, index}, {2'b01, 3'd1});
        apply(4'b1111);
        chk("t6_err", {state, seq_err}, {2'b10, 1'b1});
        apply(4'b1010);
        chk("t6_errhold", state, 2'b10);
        clear = 1'b1;
        apply(4'b0000);
        clear = 1'b0;
        chk("t6_clr", {state, seq_err, index_valid}, {2'b00, 1'b0, 1'b0});
        chk("t6_clr_ill", illegal, 1'b1);
        chk("t6_clr_cyc", cycles, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
